// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM encoding, frame constants and bit-timing helpers for
//          the buffered UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Width of a counter that runs 0 .. set-1 (at least one bit).
    function automatic int symbol_cnt_width(input int set);
        return (set <= 2) ? 1 : $clog2(set);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_byte_fifo.sv
// ============================================================================
// Module : tx_byte_fifo
// Brief  : Synchronous show-ahead byte FIFO; full writes and empty reads are
//          ignored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               din,
    output logic                     full,
    input  logic                     rd_en,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module : uart_tx_buffered
// Brief  : Buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is
//          defined); ready/valid byte input feeding a FIFO and bit-timing FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW               = symbol_cnt_width(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]    C_IDX_LAST = 3'(DATA_BITS - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_serial;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic          w_bit_end;
    logic          w_pop;

    assign data_in_ready = !w_full && !rst;
    assign w_bit_end     = (r_cnt == C_CNT_LAST);
    assign w_pop         = !w_empty &&
                           ((r_state == ST_IDLE) || (r_state == ST_STOP && w_bit_end));
    assign serial_out    = r_serial;
    assign busy          = (r_state != ST_IDLE) || (fifo_count != '0);

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (data_in_valid && data_in_ready),
        .din   (data_in),
        .full  (w_full),
        .rd_en (w_pop),
        .dout  (w_head),
        .empty (w_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_cnt    <= '0;
                        r_state  <= ST_START;
                        r_serial <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                        r_serial  <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == C_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state  <= ST_PARITY;
                            r_serial <= r_parity;
`else
                            r_state  <= ST_STOP;
                            r_serial <= 1'b1;
`endif
                        end else begin
                            // Shift keeps the next bit to send at index 1.
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_state  <= ST_STOP;
                        r_serial <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            // Back-to-back frame: no idle bit between stop and start.
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state  <= ST_START;
                            r_serial <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_serial <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module : tb_uart_tx_buffered
// Brief  : Self-checking bench for uart_tx_buffered with a frame-level line
//          model; honours UART_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

    localparam int CLOCK_FREQ = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DEPTH      = 4;
    localparam int SET        = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS      = 11;
`else
    localparam int FBITS      = 10;
`endif
    localparam int FRAME_CYC  = FBITS * SET;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_buffered #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
    endtask

    // Line picture of one frame, index 0 = start bit.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Model: byte queue plus the frame currently on the line and its elapsed time.
    logic [7:0]  q[$];
    logic        m_active = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits = '1;
    logic        m_acc;
    logic [7:0]  m_din;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            m_acc = data_in_valid && (q.size() < DEPTH);
            m_din = data_in;
            if (m_active && m_t < FRAME_CYC - 1) begin
                m_t++;
            end else if (q.size() > 0) begin
                m_bits   = make_frame(q.pop_front());
                m_active = 1'b1;
                m_t      = 0;
            end else begin
                m_active = 1'b0;
            end
            if (m_acc) q.push_back(m_din);
        end
    end

    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            chk("serial_out", 32'(serial_out), m_active ? 32'(m_bits[m_t / SET]) : 32'd1);
            chk("busy", 32'(busy), 32'(m_active || q.size() != 0));
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
            chk("ready", 32'(data_in_ready), 32'(!rst && q.size() < DEPTH));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] b, output int edge_n);
        int n;
        n = 0;
        data_in       = b;
        data_in_valid = 1'b1;
        while (!data_in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) timeout_fail("push_wait");
        @(negedge clk);
        edge_n = cyc;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("idle_wait");
        repeat (3) @(negedge clk);
    endtask

    int e0;
    int e;
    int a5_bits[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        data_in = 8'h00;
        data_in_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1. reset state
        @(negedge clk);
        chk("rst_serial", 32'(serial_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(data_in_ready), 32'd1);

        // 2. single byte A5
        push(8'hA5, e0);
        data_in_valid = 1'b0;
        chk("a5_pre_start", 32'(serial_out), 32'd1);
        for (int k = 0; k < 9; k++) begin
            wait_to(e0 + 1 + SET * k + 5);
            chk("a5_bit", 32'(serial_out), 32'(a5_bits[k]));
        end
        wait_to(e0 + FRAME_CYC);
        chk("a5_busy_last", 32'(busy), 32'd1);
        wait_to(e0 + 1 + FRAME_CYC);
        chk("a5_busy_fall", 32'(busy), 32'd0);
        wait_idle();

        // 3. six bytes back-to-back
        push(8'h01, e0);
        for (int i = 2; i <= 5; i++) push(8'(i), e);
        chk("burst_count_full", 32'(fifo_count), 32'd4);
        chk("burst_ready_low", 32'(data_in_ready), 32'd0);
        push(8'h06, e);
        data_in_valid = 1'b0;
        chk("burst_06_edge", 32'(e), 32'(e0 + 2 + FRAME_CYC));
        wait_idle();

        // 4. push coinciding with STOP->START pop, then refused push when full
        push(8'h10, e0);
        push(8'h11, e);
        push(8'h12, e);
        data_in_valid = 1'b0;
        wait_to(e0 + FRAME_CYC);
        data_in = 8'h13;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("same_edge_count", 32'(fifo_count), 32'd2);
        push(8'h14, e);
        push(8'h15, e);
        data_in_valid = 1'b0;
        chk("refill_count", 32'(fifo_count), 32'd4);
        wait_to(e0 + 2 * FRAME_CYC);
        data_in = 8'h16;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("refused_count", 32'(fifo_count), 32'd3);
        chk("refused_ready", 32'(data_in_ready), 32'd1);
        wait_idle();

        // 5. reset 37 cycles into a frame of 00 with two bytes queued
        push(8'h00, e0);
        push(8'h21, e);
        push(8'h22, e);
        data_in_valid = 1'b0;
        wait_to(e0 + 1 + 37);
        chk("pre_rst_serial", 32'(serial_out), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_serial", 32'(serial_out), 32'd1);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(data_in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("post_rst_serial", 32'(serial_out), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // 6. parity bit
        push(8'h07, e0);
        data_in_valid = 1'b0;
        wait_to(e0 + 1 + 9 * SET + 5);
        chk("par07_bit", 32'(serial_out), 32'd1);
        wait_to(e0 + 1 + 10 * SET + 5);
        chk("par07_stop", 32'(serial_out), 32'd1);
        wait_to(e0 + 110);
        chk("par07_busy_last", 32'(busy), 32'd1);
        wait_to(e0 + 111);
        chk("par07_busy_fall", 32'(busy), 32'd0);
        wait_idle();
        push(8'h03, e0);
        data_in_valid = 1'b0;
        wait_to(e0 + 1 + 9 * SET + 5);
        chk("par03_bit", 32'(serial_out), 32'd0);
        wait_idle();
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
